// File: rtl/rr_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_4_1
// Purpose  : Four-producer round-robin collector with valid/ready handshakes.
//            One registered output word, tagged with its 2-bit source index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_4_1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel
);

    logic [WIDTH-1:0] w_slice [4];
    logic             w_load_ok;
    logic [1:0]       w_gnt_idx;
    logic             w_gnt_any;
    logic             w_take;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;
    logic [1:0]       r_ptr;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        assign w_slice[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign w_load_ok = !r_out_valid || out_ready;

    // Scan from the far end back toward ptr so the channel closest to ptr
    // in round-robin order is the one left standing.
    always_comb begin
        logic [1:0] v_scan;
        w_gnt_idx = 2'd0;
        w_gnt_any = 1'b0;
        v_scan    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            v_scan = r_ptr + 2'(k);
            if (in_valid[v_scan]) begin
                w_gnt_idx = v_scan;
                w_gnt_any = 1'b1;
            end
        end
    end

    assign w_take = !rst && w_load_ok && w_gnt_any;

    always_comb begin
        in_ready = 4'b0000;
        if (w_take) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
            r_ptr       <= 2'd0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_slice[w_gnt_idx];
            r_out_sel   <= w_gnt_idx;
            r_ptr       <= w_gnt_idx + 2'd1;
        end else if (r_out_valid && out_ready) begin
            // Drain with nothing to replace it: data and tag keep last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_4_1
// Purpose  : Self-checking bench for rr_mux_4_1 with a scoreboard of words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_4_1;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [3:0]         in_valid = 4'b0000;
    logic [4*WIDTH-1:0] in_data = '0;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;

    int checks   = 0;
    int failures = 0;

    // Reference state of the collector
    logic [1:0]  m_ptr   = 2'd0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_sel   = 2'd0;
    logic [7:0]  m_data  = 8'd0;
    logic        m_known = 1'b0;
    logic [9:0]  sb [$];

    rr_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus after the falling edge, check, then clock.
    task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic ordy);
        logic       found;
        logic [1:0] g;
        logic [1:0] idx;
        logic       load_ok;
        logic [3:0] exp_rdy;
        logic [9:0] word;
        rst = r; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = 2'((int'(m_ptr) + k) % 4);
            if (!found && v[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        load_ok = !m_valid || ordy;
        exp_rdy = (!r && load_ok && found) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (m_known) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("out_sel_hold", {30'd0, out_sel}, {30'd0, m_sel});
            chk("out_data_hold", {24'd0, out_data}, {24'd0, m_data});
            if (!r && m_valid && ordy) begin
                chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() != 0) begin
                    word = sb.pop_front();
                    chk("sb_sel", {30'd0, out_sel}, {30'd0, word[9:8]});
                    chk("sb_data", {24'd0, out_data}, {24'd0, word[7:0]});
                end
            end
        end
        if (r) begin
            m_valid = 1'b0; m_ptr = 2'd0; m_sel = 2'd0; m_data = 8'd0;
            m_known = 1'b1;
            sb.delete();
        end else if (exp_rdy != 4'b0000) begin
            m_valid = 1'b1;
            m_sel   = g;
            m_data  = d[g*8 +: 8];
            m_ptr   = g + 2'd1;
            sb.push_back({g, m_data});
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] quad;
        quad = 32'h1312_1110;
        @(negedge clk);

        // Reset then idle
        step(1'b1, 4'b0000, 32'd0, 1'b0);
        step(1'b1, 4'b0000, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 32'd0, 1'b1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Single request on channel 2
        step(1'b0, 4'b0100, 32'h00A5_0000, 1'b1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_sel", {30'd0, out_sel}, 32'd2);
        chk("single_data", {24'd0, out_data}, 32'hA5);
        step(1'b0, 4'b0000, 32'd0, 1'b1);

        // All four requesting from reset
        step(1'b1, 4'b0000, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 4'b1111, quad, 1'b1);

        // Backpressure with all channels requesting
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, quad, 1'b0);
        step(1'b0, 4'b1111, quad, 1'b1);
        step(1'b0, 4'b1111, quad, 1'b1);
        step(1'b0, 4'b0000, quad, 1'b1);

        // Pointer wrap and skip
        step(1'b1, 4'b0000, 32'd0, 1'b0);
        step(1'b0, 4'b1000, 32'h4400_0000, 1'b1);
        step(1'b0, 4'b0010, 32'h0000_2200, 1'b1);
        chk("skip_sel", {30'd0, out_sel}, 32'd1);
        step(1'b0, 4'b0011, 32'h0000_5566, 1'b1);
        chk("pair_first", {30'd0, out_sel}, 32'd0);
        step(1'b0, 4'b0010, 32'h0000_5566, 1'b1);
        chk("pair_second", {30'd0, out_sel}, 32'd1);
        step(1'b0, 4'b0000, 32'd0, 1'b1);

        // Reset while stalled
        step(1'b0, 4'b0100, 32'h0077_0000, 1'b1);
        step(1'b0, 4'b1111, quad, 1'b0);
        step(1'b1, 4'b1111, quad, 1'b0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel", {30'd0, out_sel}, 32'd0);
        step(1'b0, 4'b1111, quad, 1'b1);
        chk("rst_grant0", {30'd0, out_sel}, 32'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_4_1.md
# rr_mux_4_1

Four-channel to one-channel round-robin collector with valid/ready handshakes. It is the upstream counterpart of the 1:4 demultiplexer. It merges four independent producers into one registered output stream and tags each word with its 2-bit source index `out_sel`. That index can drive a downstream `demux_1_4` select directly, with `out_sel[1]` as s1 and `out_sel[0]` as s0. Arbitration is fair round-robin, so no producer can starve another.

## Interface
- `WIDTH`, default 8: data width of each channel.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  4  producer i presents a word on slice i.
- `in_data`  input  4*WIDTH  slice i is `in_data[i*WIDTH +: WIDTH]`.
- `in_ready`  output  4  one-hot or zero; the word on slice i is taken this cycle when `in_valid[i] & in_ready[i]`.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts the word this cycle.
- `out_data`  output  WIDTH  registered word.
- `out_sel`  output  2  registered source index of `out_data`.

## Operation
- The block has a single output register and a 2-bit round-robin pointer `ptr`.
- State is implied by `out_valid`:
  - EMPTY when `out_valid=0`.
  - FULL when `out_valid=1`.
- Load is allowed when `load_ok = !out_valid | out_ready`.
- Grant:
  - Scan channels `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - The first channel with `in_valid` set is `g`.
  - `in_ready` is combinational: `in_ready = load_ok ? onehot(g) : 4'b0000`, and 0 when no channel is valid.
- On grant:
  - `out_data <= slice g`.
  - `out_sel <= g`.
  - `out_valid <= 1`.
  - `ptr <= g+1` (mod 4; 3 wraps to 0).
- Drain without load: `out_valid & out_ready` with no `in_valid` set gives `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- Stall: `out_valid & !out_ready` holds the output register, `in_ready=0`, and `ptr` unchanged.
- `ptr` advances only on a grant, never on idle cycles.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on drain-and-grant in the same cycle (back-to-back), or on stall.
  - FULL→EMPTY on drain with no request.
- `in_valid` is expected to stay asserted until the handshake completes. The block does not require this: dropping a request before it is granted simply removes it from arbitration.

## Timing
- Reset (sync, `rst=1` at a clock edge):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready=0` while `rst` is high.
- Reset mid-operation discards any held word. No handshake completes in the reset cycle.
- Latency: a word accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 word/cycle when `out_ready` is held high and any channel requests.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `in_data` to any output.
- Simultaneous requests: within any window in which all four requesters remain asserted, each is granted exactly once per four grants.

## Test plan
- Reset, then `in_valid=4'b0000` for 5 cycles. Expect `out_valid=0`, `out_sel=0`, `out_data=0`, `in_ready=0` throughout.
- Single request, `WIDTH=8`: `in_valid=4'b0100`, slice2=8'hA5, `out_ready=1`.
  - Expect `in_ready=4'b0100` in the same cycle.
  - Next cycle `out_valid=1`, `out_data=8'hA5`, `out_sel=2'b10`.
- All four held valid with slices 8'h10/8'h11/8'h12/8'h13, `out_ready=1` from reset. Expect `out_sel` to repeat 0,1,2,3,0… each cycle, with matching data and no idle cycle.
- Backpressure: after a word is loaded, hold `out_ready=0` for 3 cycles with `in_valid=4'b1111`.
  - Expect `in_ready=0`, and `out_data`/`out_sel` stable.
  - Raising `out_ready` gives a drain-and-load in the same cycle, and `out_sel` advances by one.
- Pointer wrap and skip: grant channel 3, then request only channel 1. Expect the grant to go to 1 (pointer 0 skipped, no stall). A later request of `4'b0011` grants 0 first, then 1.
- Reset mid-stall: `out_valid=1`, `out_ready=0`, assert `rst` one cycle. Expect `out_valid=0`, `out_sel=0`, and `ptr` back at 0, so the next `4'b1111` request grants channel 0.
